// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg: shared definitions for the parametrised synchronous FIFO.
//   PTR_W(depth)    : pointer width for a power-of-2 depth.
//   FIFO_MODE_STD   : registered read mode selector value.
//   FIFO_MODE_FWFT  : first-word-fall-through read mode selector value.
// ---------------------------------------------------------------------------
package fifo_pkg;

   localparam int unsigned FIFO_MODE_STD  = 0;
   localparam int unsigned FIFO_MODE_FWFT = 1;

   // Pointer width; occupancy count is one bit wider to represent DEPTH.
   function automatic int unsigned PTR_W(input int unsigned depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// ---------------------------------------------------------------------------
// fifo_mem: DATA_W x DEPTH storage, one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
//   clk   in  clock
//   we    in  write enable
//   waddr in  write address
//   wdata in  write data
//   raddr in  read address
//   rdata out read data (combinational from raddr)
// ---------------------------------------------------------------------------
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 16
) (
   input  logic                      clk,
   input  logic                      we,
   input  logic [PTR_W(DEPTH)-1:0]   waddr,
   input  logic [DATA_W-1:0]         wdata,
   input  logic [PTR_W(DEPTH)-1:0]   raddr,
   output logic [DATA_W-1:0]         rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Asynchronous read port
   assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// ---------------------------------------------------------------------------
// fifo_sync_param: parametrised single-clock FIFO with occupancy count,
// programmable almost-full/almost-empty flags, sticky error flags and a
// selectable registered or first-word-fall-through read mode.
//   clk          in  clock, rising edge
//   rst          in  asynchronous active-high reset
//   wr_en        in  write request
//   d_in         in  write data
//   rd_en        in  read request (acknowledge in FWFT mode)
//   clr_err      in  synchronous clear of overflow/underflow
//   d_out        out read data
//   d_valid      out d_out holds valid data
//   full         out count == DEPTH
//   empty        out count == 0
//   almost_full  out count >= AF_THRESH
//   almost_empty out count <= AE_THRESH
//   count        out occupancy 0..DEPTH
//   overflow     out sticky: write attempted while full
//   underflow    out sticky: read attempted while empty
// ---------------------------------------------------------------------------
module fifo_sync_param
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned AF_THRESH = 12,
   parameter int unsigned AE_THRESH = 2,
   parameter int unsigned FWFT      = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [DATA_W-1:0]       d_in,
   input  logic                    rd_en,
   input  logic                    clr_err,
   output logic [DATA_W-1:0]       d_out,
   output logic                    d_valid,
   output logic                    full,
   output logic                    empty,
   output logic                    almost_full,
   output logic                    almost_empty,
   output logic [PTR_W(DEPTH):0]   count,
   output logic                    overflow,
   output logic                    underflow
);

   localparam int unsigned PW = PTR_W(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic              full_c, empty_c;
   logic              wr_acc, rd_acc;
   logic [DATA_W-1:0] rdata;

   // Status flags decoded from the registered count
   assign full_c       = (count_q == CW'(DEPTH));
   assign empty_c      = (count_q == CW'(0));
   assign full         = full_c;
   assign empty        = empty_c;
   assign almost_full  = (count_q >= CW'(AF_THRESH));
   assign almost_empty = (count_q <= CW'(AE_THRESH));
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

   // Accept decisions use the pre-edge flags, so full/empty never bypass
   assign wr_acc = wr_en & ~full_c;
   assign rd_acc = rd_en & ~empty_c;

   // Next-state for pointers, count and sticky errors
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      // A set event in the same cycle as clr_err wins
      ovf_d = (ovf_q & ~clr_err) | (wr_en & full_c);
      unf_d = (unf_q & ~clr_err) | (rd_en & empty_c);
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr_q),
      .wdata (d_in),
      .raddr (rd_ptr_q),
      .rdata (rdata)
   );

   // Read-mode output stage
   if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Head word is presented directly; rd_en only acknowledges it
      assign d_out   = rdata;
      assign d_valid = ~empty_c;
   end else begin : g_std
      logic [DATA_W-1:0] dout_q, dout_d;
      logic              dvalid_q, dvalid_d;

      always_comb begin
         dout_d   = dout_q;
         dvalid_d = rd_acc;
         if (rd_acc) dout_d = rdata;
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            dout_q   <= '0;
            dvalid_q <= 1'b0;
         end else begin
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
         end
      end

      assign d_out   = dout_q;
      assign d_valid = dvalid_q;
   end

endmodule

// File: tb/tb_fifo_sync_param.sv
// ---------------------------------------------------------------------------
// tb_fifo_sync_param: directed, table-driven bench for fifo_sync_param.
// One instance in registered read mode, one in FWFT mode (default sizes).
// ---------------------------------------------------------------------------
module tb_fifo_sync_param;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en, rd_en, clr_err;
   logic [7:0] d_in;
   logic [7:0] d_out;
   logic       d_valid, full, empty, almost_full, almost_empty;
   logic [4:0] count;
   logic       overflow, underflow;

   logic       wr_f, rd_f;
   logic [7:0] din_f;
   logic [7:0] dout_f;
   logic       dv_f, full_f, empty_f, af_f, ae_f, ovf_f, unf_f;
   logic [4:0] count_f;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fifo_sync_param #(
      .DATA_W(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(2), .FWFT(0)
   ) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .d_in(d_in), .rd_en(rd_en),
      .clr_err(clr_err), .d_out(d_out), .d_valid(d_valid), .full(full),
      .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
      .count(count), .overflow(overflow), .underflow(underflow)
   );

   fifo_sync_param #(
      .DATA_W(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(2), .FWFT(1)
   ) dut_f (
      .clk(clk), .rst(rst), .wr_en(wr_f), .d_in(din_f), .rd_en(rd_f),
      .clr_err(1'b0), .d_out(dout_f), .d_valid(dv_f), .full(full_f),
      .empty(empty_f), .almost_full(af_f), .almost_empty(ae_f),
      .count(count_f), .overflow(ovf_f), .underflow(unf_f)
   );

   typedef struct {
      logic        wr;
      logic        rd;
      logic        clr;
      logic [7:0]  din;
      logic [19:0] exp;
      string       name;
   } vec_t;

   vec_t vq[$];

   // {count, full, empty, af, ae, ovf, unf, d_valid, d_out}
   function automatic logic [19:0] pk(input int c, input logic f, input logic e,
                                      input logic af, input logic ae, input logic ov,
                                      input logic un, input logic dv, input logic [7:0] d);
      return {5'(c), f, e, af, ae, ov, un, dv, d};
   endfunction

   function automatic logic [19:0] obs();
      return {count, full, empty, almost_full, almost_empty, overflow, underflow,
              d_valid, d_out};
   endfunction

   task automatic add(input logic wr, input logic rd, input logic clr,
                      input logic [7:0] din, input logic [19:0] exp, input string name);
      vec_t v;
      v.wr = wr; v.rd = rd; v.clr = clr; v.din = din; v.exp = exp; v.name = name;
      vq.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; d_in = 8'h00;
      wr_f = 1'b0; rd_f = 1'b0; din_f = 8'h00;
   endtask

   // Reset pulse placed between edges
   task automatic pulse_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] model[$];
      logic [7:0] e;
      int c;

      idle();
      rst = 1'b1;
      #12;
      check("reset_std", 32'(obs()), 32'(pk(0, 0, 1, 0, 1, 0, 0, 0, 8'h00)));
      check("reset_fwft", 32'({count_f, full_f, empty_f, af_f, ae_f, ovf_f, unf_f, dv_f}),
            32'({5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
      @(negedge clk);
      rst = 1'b0;

      // Fill 0x00..0x0F
      for (int i = 0; i < 16; i++) begin
         c = i + 1;
         add(1'b1, 1'b0, 1'b0, 8'(i),
             pk(c, c == 16, 1'b0, c >= 12, c <= 2, 1'b0, 1'b0, 1'b0, 8'h00), "fill");
      end
      // Overflow then clear
      add(1'b1, 1'b0, 1'b0, 8'hAA, pk(16, 1, 0, 1, 0, 1, 0, 0, 8'h00), "ovf_write");
      add(1'b0, 1'b0, 1'b0, 8'h00, pk(16, 1, 0, 1, 0, 1, 0, 0, 8'h00), "ovf_hold");
      add(1'b0, 1'b0, 1'b1, 8'h00, pk(16, 1, 0, 1, 0, 0, 0, 0, 8'h00), "ovf_clr");
      add(1'b0, 1'b0, 1'b0, 8'h00, pk(16, 1, 0, 1, 0, 0, 0, 0, 8'h00), "ovf_after_clr");
      // Drain 0x00..0x0F, then underflow
      for (int j = 0; j < 16; j++) begin
         c = 15 - j;
         add(1'b0, 1'b1, 1'b0, 8'h00,
             pk(c, 1'b0, c == 0, c >= 12, c <= 2, 1'b0, 1'b0, 1'b1, 8'(j)), "drain");
      end
      add(1'b0, 1'b1, 1'b0, 8'h00, pk(0, 0, 1, 0, 1, 0, 1, 0, 8'h0F), "underflow");
      add(1'b0, 1'b0, 1'b0, 8'h00, pk(0, 0, 1, 0, 1, 0, 1, 0, 8'h0F), "unf_hold");

      foreach (vq[k]) begin
         wr_en = vq[k].wr; rd_en = vq[k].rd; clr_err = vq[k].clr; d_in = vq[k].din;
         tick();
         check(vq[k].name, 32'(obs()), 32'(vq[k].exp));
      end
      idle();

      // Wrap with simultaneous access
      pulse_reset();
      check("reset_clears_unf", 32'(obs()), 32'(pk(0, 0, 1, 0, 1, 0, 0, 0, 8'h00)));
      for (int i = 0; i < 10; i++) begin
         wr_en = 1'b1; d_in = 8'h80 + 8'(i);
         model.push_back(d_in);
         tick();
      end
      idle();
      for (int k = 0; k < 40; k++) begin
         wr_en = 1'b1; rd_en = 1'b1; d_in = 8'hC0 + 8'(k);
         e = model.pop_front();
         model.push_back(d_in);
         tick();
         check("wrap_rw", 32'({count, d_valid, overflow, underflow, d_out}),
               32'({5'd10, 1'b1, 1'b0, 1'b0, e}));
      end
      idle();

      // Simultaneous read/write while empty, then while full
      pulse_reset();
      wr_en = 1'b1; rd_en = 1'b1; d_in = 8'h77;
      tick();
      idle();
      check("rw_empty", 32'(obs()), 32'(pk(1, 0, 0, 0, 1, 0, 1, 0, 8'h00)));
      for (int i = 0; i < 15; i++) begin
         wr_en = 1'b1; d_in = 8'h78 + 8'(i);
         tick();
      end
      idle();
      check("rw_prefull", 32'(obs()), 32'(pk(16, 1, 0, 1, 0, 0, 1, 0, 8'h00)));
      wr_en = 1'b1; rd_en = 1'b1; d_in = 8'hEE;
      tick();
      idle();
      check("rw_full", 32'(obs()), 32'(pk(15, 0, 0, 1, 0, 1, 1, 1, 8'h77)));

      // FWFT first word and acknowledge
      din_f = 8'h5C; wr_f = 1'b1;
      tick();
      idle();
      check("fwft_first", 32'({dout_f, dv_f, count_f, empty_f}),
            32'({8'h5C, 1'b1, 5'd1, 1'b0}));
      rd_f = 1'b1;
      tick();
      idle();
      check("fwft_ack", 32'({dv_f, empty_f, count_f, unf_f}),
            32'({1'b0, 1'b1, 5'd0, 1'b0}));
      wr_f = 1'b1; din_f = 8'hA1;
      tick();
      din_f = 8'hA2;
      tick();
      idle();
      check("fwft_head", 32'({dout_f, dv_f, count_f}), 32'({8'hA1, 1'b1, 5'd2}));
      rd_f = 1'b1;
      tick();
      idle();
      check("fwft_next", 32'({dout_f, dv_f, count_f}), 32'({8'hA2, 1'b1, 5'd1}));

      // Asynchronous reset mid-operation
      pulse_reset();
      for (int i = 0; i < 8; i++) begin
         wr_en = 1'b1; d_in = 8'h41 + 8'(i);
         tick();
      end
      idle();
      rd_en = 1'b1;
      tick();
      idle();
      check("pre_rst", 32'({count, d_valid, d_out}), 32'({5'd7, 1'b1, 8'h41}));
      #2;
      rst = 1'b1;
      #1;
      check("async_rst", 32'(obs()), 32'(pk(0, 0, 1, 0, 1, 0, 0, 0, 8'h00)));
      check("async_rst_fwft", 32'({count_f, dv_f, empty_f}), 32'({5'd0, 1'b0, 1'b1}));
      #1;
      rst = 1'b0;
      wr_en = 1'b1; d_in = 8'h33;
      tick();
      idle();
      rd_en = 1'b1;
      tick();
      idle();
      check("post_rst_data", 32'(obs()), 32'(pk(0, 0, 1, 0, 1, 0, 0, 1, 8'h33)));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
